// File: rtl/tdc_result_tx_if.sv
// Result-in / UART-byte-out bundle for the TDC result framer.
// master = readout logic + UART TX core side, slave = framer.
interface tdc_result_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   result;
  logic          result_valid;
  logic          enable;
  logic          clear_ovf;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_done;

  modport master (
    output result, result_valid, enable, clear_ovf, tx_busy,
    input  tx_data, new_tx_data, fifo_count, overflow, frame_done
  );

  modport slave (
    input  result, result_valid, enable, clear_ovf, tx_busy,
    output tx_data, new_tx_data, fifo_count, overflow, frame_done
  );
endinterface

// File: rtl/tdc_result_tx.sv
// Buffers 32-bit TDC results and frames each one as
// HEADER, seq, 4 result bytes (MSB first), XOR checksum onto the UART TX handshake.
module tdc_result_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input logic            clk,
  input logic            rst,
  tdc_result_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop, send, done, ovf;
  logic [31:0]   word;
  logic [2:0]    idx;
  logic [7:0]    seq, cur_byte, tx_last, chk;

  // A full FIFO drops the new result even if the head is popped this cycle.
  assign full = (count == CW'(FIFO_DEPTH));
  assign push = bus.result_valid && !full;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.result;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      // A fresh drop beats a simultaneous clear.
      if (bus.result_valid && full) ovf <= 1'b1;
      else if (bus.clear_ovf)       ovf <= 1'b0;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable && count != '0) state_nxt = SEND;
      SEND:    if (!bus.tx_busy)              state_nxt = GAP;
      GAP:     state_nxt = (idx == 3'd6) ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop  = (state == IDLE) && bus.enable && (count != '0);
    send = (state == SEND) && !bus.tx_busy;
    done = (state == GAP) && (idx == 3'd6);
  end

  assign chk = seq ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];

  always_comb begin
    case (idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = seq;
      3'd2:    cur_byte = word[31:24];
      3'd3:    cur_byte = word[23:16];
      3'd4:    cur_byte = word[15:8];
      3'd5:    cur_byte = word[7:0];
      default: cur_byte = chk;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word    <= '0;
      idx     <= '0;
      seq     <= '0;
      tx_last <= '0;
    end else begin
      if (pop) begin
        word <= mem[rd_ptr];
        idx  <= '0;
      end
      if (state == GAP && !done) idx <= idx + 3'd1;
      if (done) seq <= seq + 8'd1;
      if (send) tx_last <= cur_byte;
    end

  // Byte goes out in the SEND cycle itself; between strobes tx_data keeps the last byte.
  assign bus.tx_data     = send ? cur_byte : tx_last;
  assign bus.new_tx_data = send;
  assign bus.frame_done  = done;
  assign bus.fifo_count  = count;
  assign bus.overflow    = ovf;
endmodule
